// File: rtl/stream_framer_pkg.sv
// Shared constants for the stream framer and other config-bus clients.
package stream_framer_pkg;

    // Default config-bus decode values shared by every client on the bus
    localparam int unsigned DEF_CONFIG_ID   = 2;
    localparam int unsigned DEF_CONFIG_ADDR = 23;
    localparam int unsigned DEF_CONFIG_DATA = 24;

    // One-hot state bit positions
    localparam int unsigned ST_IDLE    = 0;
    localparam int unsigned ST_CONFIG  = 1;
    localparam int unsigned ST_ACTIVE  = 2;
    localparam int unsigned ST_DONE    = 3;
    localparam int unsigned NUM_STATES = 4;

    typedef enum logic [NUM_STATES-1:0] {
        S_IDLE   = NUM_STATES'(1 << ST_IDLE),
        S_CONFIG = NUM_STATES'(1 << ST_CONFIG),
        S_ACTIVE = NUM_STATES'(1 << ST_ACTIVE),
        S_DONE   = NUM_STATES'(1 << ST_DONE)
    } state_e;

endpackage

// File: rtl/stream_framer_skid.sv
// Two-entry skid buffer: registered outputs, ready driven only from local state.
module stream_skid #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire_c;
    logic             out_free_c;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Next-state: drain skid first, else pass input to output or park it in skid
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        in_fire_c    = in_valid & ~skid_valid_q;
        out_free_c   = ~out_valid_q | out_ready;

        if (skid_valid_q) begin
            if (out_ready) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire_c) begin
            if (out_free_c) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Buffer registers; reset empties both entries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/stream_framer.sv
// Config-bus programmed framer: passes a fixed number of words and tags the last.
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int unsigned CONFIG_ID     = DEF_CONFIG_ID,
    parameter int unsigned CONFIG_ADDR   = DEF_CONFIG_ADDR,
    parameter int unsigned CONFIG_DATA   = DEF_CONFIG_DATA,
    parameter int unsigned CONFIG_AWIDTH = 5,
    parameter int unsigned CONFIG_DWIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CONFIG_AWIDTH-1:0] cfg_addr,
    input  logic [CONFIG_DWIDTH-1:0] cfg_data,
    input  logic                     cfg_valid,
    input  logic [DATA_WIDTH-1:0]    up_data,
    input  logic                     up_valid,
    output logic                     up_ready,
    output logic [DATA_WIDTH-1:0]    dn_data,
    output logic                     dn_valid,
    output logic                     dn_last,
    input  logic                     dn_ready,
    output logic                     done
);

    localparam int unsigned SKID_W = DATA_WIDTH + 1;

    logic [CONFIG_AWIDTH-1:0] cfg_addr_q;
    logic [CONFIG_DWIDTH-1:0] cfg_data_q;
    logic                     cfg_valid_q;

    state_e                   state_q, state_d;
    logic [CONFIG_DWIDTH-1:0] len_q, len_d;
    logic [CONFIG_DWIDTH-1:0] cnt_q, cnt_d;
    logic                     done_q, done_d;

    logic                     skid_in_ready;
    logic                     skid_out_valid;
    logic [SKID_W-1:0]        skid_out_data;

    logic                     id_hit_c;
    logic                     len_hit_c;
    logic                     up_fire_c;
    logic                     word_last_c;
    logic                     dn_fire_last_c;

    // Config bus is sampled once before any decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            cfg_valid_q <= 1'b0;
        end else begin
            cfg_addr_q  <= cfg_addr;
            cfg_data_q  <= cfg_data;
            cfg_valid_q <= cfg_valid;
        end
    end

    assign id_hit_c  = cfg_valid_q && (cfg_addr_q == CONFIG_AWIDTH'(CONFIG_ADDR))
                                   && (cfg_data_q == CONFIG_DWIDTH'(CONFIG_ID));
    assign len_hit_c = cfg_valid_q && (cfg_addr_q == CONFIG_AWIDTH'(CONFIG_DATA));

    assign up_ready       = state_q[ST_ACTIVE] & skid_in_ready;
    assign up_fire_c      = up_valid & up_ready;
    assign word_last_c    = (cnt_q == len_q - CONFIG_DWIDTH'(1));
    assign dn_fire_last_c = skid_out_valid & dn_ready & skid_out_data[SKID_W-1];

    // Frame sequencing: config handshake, word counting, completion pulse
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (id_hit_c) state_d = S_CONFIG;
            end
            S_CONFIG: begin
                if (len_hit_c) begin
                    len_d   = cfg_data_q;
                    cnt_d   = '0;
                    state_d = (cfg_data_q == '0) ? S_IDLE : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (up_fire_c) begin
                    cnt_d = cnt_q + CONFIG_DWIDTH'(1);
                    if (word_last_c) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (dn_fire_last_c) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    stream_skid #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({word_last_c, up_data}),
        .in_valid  (up_fire_c),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out_data),
        .out_valid (skid_out_valid),
        .out_ready (dn_ready)
    );

    assign dn_valid = skid_out_valid;
    assign dn_last  = skid_out_data[SKID_W-1];
    assign dn_data  = skid_out_data[DATA_WIDTH-1:0];
    assign done     = done_q;

endmodule

// File: tb/tb_stream_framer.sv
// Self-checking bench for stream_framer: vector table, reset corner, random frames.
module tb_stream_framer;
    import stream_framer_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned W  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_valid;
    logic [W-1:0]  up_data;
    logic          up_valid;
    logic          up_ready;
    logic [W-1:0]  dn_data;
    logic          dn_valid;
    logic          dn_last;
    logic          dn_ready;
    logic          done;

    stream_framer dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .up_data   (up_data),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .dn_data   (dn_data),
        .dn_valid  (dn_valid),
        .dn_last   (dn_last),
        .dn_ready  (dn_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    int unsigned   cyc   = 0;

    logic [W-1:0]  src[$];
    logic [W-1:0]  src_ref[$];
    logic [W-1:0]  sent[$];
    logic [W:0]    got[$];
    int unsigned   cur_len;
    int unsigned   n_done;
    bit            exp_done;
    bit            stalled;
    logic [W:0]    stall_word;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    bit            c_vld;

    typedef struct {
        int unsigned id;
        int unsigned len;
        int unsigned mode;
        bit          inject;
        int unsigned exp_words;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit gen_rdy(input int unsigned mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    function automatic bit gen_vld(input int unsigned mode);
        if (mode == 2) return $urandom_range(0, 3) != 0;
        return 1'b1;
    endfunction

    // One clock: check what the DUT shows, then drive inputs for the next edge
    task automatic cycle(input bit rdy, input bit vld);
        @(negedge clk);
        if (rst) begin
            chk("done_pulse", 64'(done), 64'(exp_done));
            if (done) n_done++;
            if (stalled) begin
                chk("stall_valid", 64'(dn_valid), 64'd1);
                chk("stall_word", 64'({dn_last, dn_data}), 64'(stall_word));
            end
        end
        dn_ready  = rdy;
        cfg_addr  = c_addr;
        cfg_data  = c_data;
        cfg_valid = c_vld;
        c_vld     = 1'b0;
        up_valid  = vld && (src.size() > 0);
        up_data   = (src.size() > 0) ? src[0] : '0;
        exp_done  = 1'b0;
        if (dn_valid && dn_ready) begin
            got.push_back({dn_last, dn_data});
            if (cur_len != 0 && got.size() == int'(cur_len)) exp_done = 1'b1;
        end
        stalled    = dn_valid && !dn_ready;
        stall_word = {dn_last, dn_data};
        if (up_valid && up_ready) sent.push_back(src.pop_front());
        cyc++;
    endtask

    task automatic new_frame(input int unsigned nwords, input bit rand_data, input logic [W-1:0] base,
                             input int unsigned exp_len);
        src.delete();
        sent.delete();
        got.delete();
        n_done  = 0;
        cur_len = exp_len;
        for (int i = 0; i < int'(nwords); i++)
            src.push_back(rand_data ? W'($urandom) : base + W'(i));
        src_ref = src;
    endtask

    task automatic run_frame(input int unsigned id, input int unsigned len, input int unsigned mode,
                             input bit inject, input int unsigned exp_len, input bit rand_data,
                             input string tag);
        int unsigned k;
        int unsigned inj;
        logic [W:0]  ew;
        new_frame(len + 4, rand_data, W'(32'hA0), exp_len);
        c_addr = AW'(DEF_CONFIG_ADDR); c_data = DW'(id);  c_vld = 1'b1;
        cycle(gen_rdy(mode), gen_vld(mode));
        c_addr = AW'(DEF_CONFIG_DATA); c_data = DW'(len); c_vld = 1'b1;
        cycle(gen_rdy(mode), gen_vld(mode));
        k   = 0;
        inj = 0;
        while (k < 400) begin
            if (exp_len > 0 && got.size() >= int'(exp_len)) break;
            if (exp_len == 0 && k >= 12) break;
            if (inject && inj == 0 && sent.size() >= 1) begin
                c_addr = AW'(DEF_CONFIG_ADDR); c_data = DW'(2); c_vld = 1'b1; inj = 1;
            end else if (inject && inj == 1) begin
                c_addr = AW'(DEF_CONFIG_DATA); c_data = DW'(9); c_vld = 1'b1; inj = 2;
            end
            cycle(gen_rdy(mode), gen_vld(mode));
            k++;
        end
        repeat (4) cycle(1'b1, 1'b1);
        chk({tag, "_nout"},  64'(got.size()),  64'(exp_len));
        chk({tag, "_nsent"}, 64'(sent.size()), 64'(exp_len));
        for (int i = 0; i < got.size() && i < int'(exp_len); i++) begin
            ew = {(i == int'(exp_len) - 1), src_ref[i]};
            chk($sformatf("%s_word%0d", tag, i), 64'(got[i]), 64'(ew));
        end
        chk({tag, "_ndone"},   64'(n_done),   64'((exp_len > 0) ? 1 : 0));
        chk({tag, "_upready"}, 64'(up_ready), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        int unsigned rid;
        int unsigned rlen;
        rst = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_valid = 1'b0;
        up_data = '0; up_valid = 1'b0; dn_ready = 1'b0;
        c_addr = '0; c_data = '0; c_vld = 1'b0;
        exp_done = 1'b0; stalled = 1'b0; stall_word = '0; n_done = 0; cur_len = 0;

        //           id  len mode inject expected words
        vecs[0] = '{32'd2, 32'd4, 32'd0, 1'b0, 32'd4};
        vecs[1] = '{32'd2, 32'd3, 32'd1, 1'b0, 32'd3};
        vecs[2] = '{32'd5, 32'd8, 32'd0, 1'b0, 32'd0};
        vecs[3] = '{32'd2, 32'd0, 32'd0, 1'b0, 32'd0};
        vecs[4] = '{32'd2, 32'd4, 32'd0, 1'b1, 32'd4};
        vecs[5] = '{32'd2, 32'd1, 32'd1, 1'b0, 32'd1};

        repeat (3) @(negedge clk);
        chk("rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("rst_dn_last",  64'(dn_last),  64'd0);
        chk("rst_dn_data",  64'(dn_data),  64'd0);
        chk("rst_up_ready", 64'(up_ready), 64'd0);
        chk("rst_done",     64'(done),     64'd0);
        rst = 1'b1;
        repeat (2) cycle(1'b1, 1'b0);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].id, vecs[i].len, vecs[i].mode, vecs[i].inject,
                      vecs[i].exp_words, 1'b0, $sformatf("vec%0d", i));

        // Reset in the middle of a long frame, then a short frame afterwards
        new_frame(20, 1'b0, W'(32'hB0), 16);
        c_addr = AW'(DEF_CONFIG_ADDR); c_data = DW'(2);  c_vld = 1'b1;
        cycle(1'b1, 1'b1);
        c_addr = AW'(DEF_CONFIG_DATA); c_data = DW'(16); c_vld = 1'b1;
        cycle(1'b1, 1'b1);
        k = 0;
        while (sent.size() < 6 && k < 100) begin
            cycle(1'b1, 1'b1);
            k++;
        end
        chk("midrst_sent", 64'(sent.size()), 64'd6);
        #1 rst = 1'b0;
        #1;
        chk("midrst_dn_valid", 64'(dn_valid), 64'd0);
        chk("midrst_dn_last",  64'(dn_last),  64'd0);
        chk("midrst_dn_data",  64'(dn_data),  64'd0);
        chk("midrst_up_ready", 64'(up_ready), 64'd0);
        chk("midrst_done",     64'(done),     64'd0);
        up_valid = 1'b0; cfg_valid = 1'b0; c_vld = 1'b0;
        stalled = 1'b0; exp_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b0);
        chk("postrst_done",  64'(done),     64'd0);
        chk("postrst_valid", 64'(dn_valid), 64'd0);
        run_frame(2, 2, 0, 1'b0, 2, 1'b0, "postrst");

        // Random frames against the queue model
        for (int i = 0; i < 20; i++) begin
            rid  = ($urandom_range(0, 4) == 0) ? 32'd7 : 32'd2;
            rlen = $urandom_range(0, 12);
            run_frame(rid, rlen, $urandom_range(0, 2), 1'b0, (rid == 2) ? rlen : 0, 1'b1,
                      $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_framer.md
STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 SHALL have parameter CONFIG_ID, default 2, which is the ID word that selects this block on the config bus.
REQ-002 SHALL have parameter CONFIG_ADDR, default 23, which is the config address carrying the ID word.
REQ-003 SHALL have parameter CONFIG_DATA, default 24, which is the config address carrying the frame-length word.
REQ-004 SHALL have parameters CONFIG_AWIDTH (default 5), CONFIG_DWIDTH (default 32) and DATA_WIDTH (default 32), which set the config address, config data and stream widths.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port cfg_addr, input, CONFIG_AWIDTH bits: config bus address.
REQ-008 SHALL have port cfg_data, input, CONFIG_DWIDTH bits: config bus data.
REQ-009 SHALL have port cfg_valid, input, 1 bit: config bus strobe.
REQ-010 SHALL have ports up_data (input, DATA_WIDTH), up_valid (input, 1) and up_ready (output, 1): the upstream stream from the memory read engine.
REQ-011 SHALL have ports dn_data (output, DATA_WIDTH), dn_valid (output, 1), dn_last (output, 1) and dn_ready (input, 1): the framed downstream stream.
REQ-012 SHALL have port done, output, 1 bit: single-cycle pulse when a frame completes.

Function
REQ-013 SHALL register cfg_addr, cfg_data and cfg_valid for one cycle before decoding; all decode uses the registered copies.
REQ-014 SHALL use a one-hot FSM with states IDLE, CONFIG, ACTIVE and DONE.
REQ-015 IDLE -> CONFIG SHALL occur when the registered address equals CONFIG_ADDR, the registered valid is high and the registered data equals CONFIG_ID.
REQ-016 In CONFIG, a registered strobe at CONFIG_DATA SHALL latch the frame length; length 0 -> IDLE, nonzero -> ACTIVE.
REQ-017 All other config writes SHALL be ignored: wrong ID, any write outside IDLE/CONFIG, and writes at other addresses while in CONFIG.
REQ-018 up_ready SHALL be low outside ACTIVE; in ACTIVE it SHALL equal "skid buffer can accept"; a transfer occurs when up_valid and up_ready are both high.
REQ-019 A word counter (CONFIG_DWIDTH bits) SHALL clear on entry to ACTIVE and increment per upstream transfer; it SHALL never wrap within a frame.
REQ-020 The word whose counter value equals length-1 SHALL be tagged last; the tag SHALL travel with the data through the buffer.
REQ-021 After the last upstream transfer, the FSM SHALL enter DONE and hold up_ready low.
REQ-022 DONE -> IDLE SHALL occur when the last word is accepted downstream (dn_valid, dn_ready and dn_last all high); done SHALL pulse high for exactly that one cycle.
REQ-023 The output path SHALL be a 2-entry skid buffer: full throughput, registered dn_valid/dn_data/dn_last, and up_ready not combinationally dependent on dn_ready.
REQ-024 Upstream-to-downstream latency SHALL be 1 cycle when the buffer is empty.
REQ-025 dn_data and dn_last SHALL stay stable while dn_valid is high and dn_ready is low.
REQ-026 A config match arriving while in ACTIVE or DONE SHALL be dropped, not queued.

Reset
REQ-027 On rst low (asynchronous): state = IDLE, skid buffer empty, counter 0, length 0, registered cfg_valid 0.
REQ-028 During reset: dn_valid = 0, dn_last = 0, up_ready = 0, done = 0; dn_data = 0.
REQ-029 Reset mid-frame SHALL discard buffered words with no done pulse; release SHALL be synchronised by the instantiating level.

Structure
REQ-030 A shared package SHALL hold the FSM state index constants and the default CONFIG_ID/CONFIG_ADDR/CONFIG_DATA values used by all config-bus clients.
REQ-031 The skid buffer SHALL be a sub-module named stream_skid, parameterised by width, carrying {last, data}.

Verification
REQ-032 Config ID=2, length=4; push words 0xA0..0xA3 with dn_ready=1 -> 4 outputs, dn_last only on 0xA3, done one cycle after 0xA3 accepted, then IDLE.
REQ-033 Length=3 with dn_ready toggling 1,0,0,1...; up_valid constant -> no word lost or duplicated, data stable while stalled, dn_last on 3rd word.
REQ-034 ID=5 at addr 23, then length 8 at addr 24 -> remains IDLE, up_ready stays 0, no output.
REQ-035 ID=2 then length=0 -> returns to IDLE, no output, no done.
REQ-036 Length=16, assert rst low after word 6 -> all outputs 0 immediately; after release a new length=2 frame completes normally.
REQ-037 During an active length=4 frame, write ID=2 / length=9 -> ignored; frame ends after 4 words; block is idle afterwards.
